// File: rtl/timer_stop_ctrl_pkg.sv
// Shared command codes, state encoding and helpers for the timer run/halt/step controller.
package timer_stop_ctrl_pkg;

  localparam int CMD_W = 3;

  localparam logic [CMD_W-1:0] CMD_NOP      = 3'd0;
  localparam logic [CMD_W-1:0] CMD_RUN      = 3'd1;
  localparam logic [CMD_W-1:0] CMD_HALT     = 3'd2;
  localparam logic [CMD_W-1:0] CMD_STEP_TP  = 3'd3;
  localparam logic [CMD_W-1:0] CMD_STEP_MCT = 3'd4;
  localparam logic [CMD_W-1:0] CMD_STEP_INS = 3'd5;
  localparam logic [CMD_W-1:0] CMD_BURST    = 3'd6;
  localparam logic [CMD_W-1:0] CMD_RSVD     = 3'd7;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_STOPPING = 3'd1,
    ST_HALTED   = 3'd2,
    ST_STEP_TP  = 3'd3,
    ST_STEP_MCT = 3'd4,
    ST_STEP_INS = 3'd5,
    ST_BURST    = 3'd6
  } state_e;

  // Commands that never raise CMD_ERR while a step or burst is in flight.
  function automatic logic is_quiet(input logic [CMD_W-1:0] cmd);
    return (cmd == CMD_NOP) || (cmd == CMD_HALT);
  endfunction

endpackage

// File: rtl/timer_cmd_arb.sv
// Two-source fixed-priority command arbiter: host always wins over the panel.
// Handshake: a command transfers in any cycle where VALID && READY; the
// requester keeps CMD/ARG stable while VALID is high.
module timer_cmd_arb
  import timer_stop_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             accept_en_i,
  input  logic             h_valid_i,
  input  logic [CMD_W-1:0] h_cmd_i,
  input  logic [CNT_W-1:0] h_arg_i,
  input  logic             p_valid_i,
  input  logic [CMD_W-1:0] p_cmd_i,
  input  logic [CNT_W-1:0] p_arg_i,
  output logic             h_ready_o,
  output logic             p_ready_o,
  output logic             acc_o,
  output logic [CMD_W-1:0] cmd_o,
  output logic [CNT_W-1:0] arg_o
);

  assign h_ready_o = accept_en_i;
  assign p_ready_o = accept_en_i && !h_valid_i;
  assign acc_o     = (h_valid_i && h_ready_o) || (p_valid_i && p_ready_o);
  assign cmd_o     = h_valid_i ? h_cmd_i : p_cmd_i;
  assign arg_o     = h_valid_i ? h_arg_i : p_arg_i;

endmodule

// File: rtl/timer_stop_ctrl.sv
// Run/halt/step controller driving the AGC timer STOP input; freezes only on
// timepulse, MCT or instruction boundaries.
module timer_stop_ctrl
  import timer_stop_ctrl_pkg::*;
#(
  parameter bit START_HALTED = 1'b1,
  parameter int CNT_W        = 8,
  parameter int MCT_CNT_W    = 16
) (
  input  logic                 SIM_CLK,
  input  logic                 RESET,
  input  logic                 TPEND,
  input  logic                 MCTEND,
  input  logic                 INSTEND,
  input  logic                 H_VALID,
  output logic                 H_READY,
  input  logic [CMD_W-1:0]     H_CMD,
  input  logic [CNT_W-1:0]     H_ARG,
  input  logic                 P_VALID,
  output logic                 P_READY,
  input  logic [CMD_W-1:0]     P_CMD,
  input  logic [CNT_W-1:0]     P_ARG,
  output logic                 STOP,
  output logic                 HALTED,
  output logic                 BUSY,
  output logic                 CMD_ERR,
  output logic [MCT_CNT_W-1:0] MCT_COUNT,
  output logic [2:0]           dbg_state_o
);

  localparam logic [CNT_W:0]     CNT_ONE  = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W:0]     CNT_FULL = {1'b1, {CNT_W{1'b0}}};
  localparam logic [MCT_CNT_W-1:0] MCT_ONE = {{(MCT_CNT_W-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [CNT_W:0]       cnt_q, cnt_d;
  logic [MCT_CNT_W-1:0] mct_q, mct_d;
  logic                 stop_q, stop_d;
  logic                 halted_q, halted_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;

  logic                 accept_en;
  logic                 acc;
  logic [CMD_W-1:0]     cmd;
  logic [CNT_W-1:0]     arg;

  assign accept_en = (state_q != ST_STOPPING);

  timer_cmd_arb #(.CNT_W(CNT_W)) u_arb (
    .accept_en_i (accept_en),
    .h_valid_i   (H_VALID),
    .h_cmd_i     (H_CMD),
    .h_arg_i     (H_ARG),
    .p_valid_i   (P_VALID),
    .p_cmd_i     (P_CMD),
    .p_arg_i     (P_ARG),
    .h_ready_o   (H_READY),
    .p_ready_o   (P_READY),
    .acc_o       (acc),
    .cmd_o       (cmd),
    .arg_o       (arg)
  );

  always_ff @(posedge SIM_CLK) begin
    if (RESET) begin
      state_q  <= START_HALTED ? ST_HALTED : ST_RUN;
      cnt_q    <= '0;
      mct_q    <= '0;
      stop_q   <= START_HALTED;
      halted_q <= START_HALTED;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mct_q    <= mct_d;
      stop_q   <= stop_d;
      halted_q <= halted_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  // Boundary pulses are ignored in HALTED: STOP is still high in that cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (acc) begin
          if (cmd == CMD_HALT) state_d = ST_STOPPING;
          else if ((cmd != CMD_RUN) && (cmd != CMD_NOP)) err_d = 1'b1;
        end
      end
      ST_STOPPING: begin
        if (MCTEND) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (acc) begin
          case (cmd)
            CMD_RUN:      state_d = ST_RUN;
            CMD_STEP_TP:  state_d = ST_STEP_TP;
            CMD_STEP_MCT: state_d = ST_STEP_MCT;
            CMD_STEP_INS: state_d = ST_STEP_INS;
            CMD_BURST: begin
              state_d = ST_BURST;
              cnt_d   = (arg == '0) ? CNT_FULL : {1'b0, arg};
            end
            CMD_RSVD:     err_d = 1'b1;
            default:      ;
          endcase
        end
      end
      ST_STEP_TP: begin
        if (TPEND) state_d = ST_HALTED;
        if (acc && !is_quiet(cmd)) err_d = 1'b1;
      end
      ST_STEP_MCT: begin
        if (MCTEND) state_d = ST_HALTED;
        if (acc && !is_quiet(cmd)) err_d = 1'b1;
      end
      ST_STEP_INS: begin
        if (INSTEND) state_d = ST_HALTED;
        if (acc && !is_quiet(cmd)) err_d = 1'b1;
      end
      ST_BURST: begin
        // A HALT arriving with an MCTEND still waits for the following MCTEND.
        if (acc && (cmd == CMD_HALT)) begin
          state_d = ST_STOPPING;
        end else begin
          if (acc && (cmd != CMD_NOP)) err_d = 1'b1;
          if (MCTEND) begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) state_d = ST_HALTED;
          end
        end
      end
      default: state_d = ST_HALTED;
    endcase
  end

  always_comb begin
    stop_d   = (state_d == ST_HALTED);
    halted_d = (state_d == ST_HALTED);
    busy_d   = (state_d != ST_HALTED) && (state_d != ST_RUN);
    mct_d    = (MCTEND && !stop_q) ? (mct_q + MCT_ONE) : mct_q;
  end

  assign STOP        = stop_q;
  assign HALTED      = halted_q;
  assign BUSY        = busy_q;
  assign CMD_ERR     = err_q;
  assign MCT_COUNT   = mct_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_timer_stop_ctrl.sv
// Bench for timer_stop_ctrl: directed vector table, hand-written corner sequences
// and randomized traffic against a behavioural model.
module tb_timer_stop_ctrl;

  localparam int CNT_W     = 8;
  localparam int MCT_CNT_W = 16;

  localparam int C_NOP = 0, C_RUN = 1, C_HALT = 2, C_STP = 3, C_SMCT = 4,
                 C_SINS = 5, C_BURST = 6, C_RSVD = 7;
  localparam int K_TP = 0, K_MCT = 1, K_INS = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                 tp, mct, ins;
  logic                 h_valid, p_valid;
  logic [2:0]           h_cmd, p_cmd;
  logic [CNT_W-1:0]     h_arg, p_arg;
  logic                 h_ready, p_ready;
  logic                 stop, halted, busy, cmd_err;
  logic [MCT_CNT_W-1:0] mct_count;
  logic [2:0]           dbg_state;

  timer_stop_ctrl #(.START_HALTED(1'b1), .CNT_W(CNT_W), .MCT_CNT_W(MCT_CNT_W)) dut (
    .SIM_CLK(clk), .RESET(rst), .TPEND(tp), .MCTEND(mct), .INSTEND(ins),
    .H_VALID(h_valid), .H_READY(h_ready), .H_CMD(h_cmd), .H_ARG(h_arg),
    .P_VALID(p_valid), .P_READY(p_ready), .P_CMD(p_cmd), .P_ARG(p_arg),
    .STOP(stop), .HALTED(halted), .BUSY(busy), .CMD_ERR(cmd_err),
    .MCT_COUNT(mct_count), .dbg_state_o(dbg_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the timer is either halted, draining to the next MCT
  // boundary, or free-running for m_left more events of kind m_kind
  // (m_left < 0 means unbounded). m_intr marks runs a HALT may cut short.
  bit m_halted, m_stopping, m_intr, m_err;
  int m_left, m_kind, m_cnt;
  logic [31:0] exp_q[$];

  task automatic m_go(input int left, input int kind, input bit intr);
    m_halted = 0; m_left = left; m_kind = kind; m_intr = intr;
  endtask

  task automatic model_next(input bit acc, input int cmd, input int arg);
    bit ev;
    if (rst) begin
      m_halted = 1; m_stopping = 0; m_left = -1; m_kind = K_MCT; m_intr = 1;
      m_err = 0; m_cnt = 0;
      return;
    end
    if (!m_halted && mct) m_cnt = (m_cnt + 1) % (1 << MCT_CNT_W);
    m_err = 0;
    if (m_halted) begin
      if (acc) begin
        case (cmd)
          C_RUN:   m_go(-1, K_MCT, 1);
          C_STP:   m_go(1, K_TP, 0);
          C_SMCT:  m_go(1, K_MCT, 0);
          C_SINS:  m_go(1, K_INS, 0);
          C_BURST: m_go((arg == 0) ? (1 << CNT_W) : arg, K_MCT, 1);
          C_RSVD:  m_err = 1;
          default: ;
        endcase
      end
    end else if (m_stopping) begin
      if (mct) begin m_stopping = 0; m_halted = 1; end
    end else begin
      ev = (m_kind == K_TP) ? tp : (m_kind == K_MCT) ? mct : ins;
      if (acc && cmd == C_HALT && m_intr) begin
        m_stopping = 1;
      end else begin
        if (acc && !(cmd == C_NOP || cmd == C_HALT || (cmd == C_RUN && m_left < 0))) m_err = 1;
        if (ev && m_left > 0) begin
          m_left--;
          if (m_left == 0) m_halted = 1;
        end
      end
    end
  endtask

  bit smp_hr, smp_pr, acc_h, acc_p;

  // One clock: inputs already driven after a negedge; check READY, advance the
  // model, then check the registered outputs at the next negedge.
  task automatic tick();
    bit en, acc;
    int cmd, arg;
    bit e_busy;
    #1;
    en = !m_stopping;
    smp_hr = h_ready; smp_pr = p_ready;
    chk("h_ready", h_ready, en);
    chk("p_ready", p_ready, en && !h_valid);
    acc_h = h_valid && en;
    acc_p = p_valid && en && !h_valid;
    acc = acc_h || acc_p;
    cmd = acc_h ? int'(h_cmd) : int'(p_cmd);
    arg = acc_h ? int'(h_arg) : int'(p_arg);
    model_next(acc, cmd, arg);
    @(posedge clk);
    @(negedge clk);
    e_busy = !m_halted && (m_stopping || m_left >= 0);
    exp_q.push_back({m_halted, m_halted, e_busy, m_err, 12'd0, m_cnt[15:0]});
    chk("stop",      stop,      exp_q[0][31]);
    chk("halted",    halted,    exp_q[0][30]);
    chk("busy",      busy,      exp_q[0][29]);
    chk("cmd_err",   cmd_err,   exp_q[0][28]);
    chk("mct_count", mct_count, exp_q[0][15:0]);
    void'(exp_q.pop_front());
  endtask

  // driver tasks
  task automatic idle();
    h_valid = 0; p_valid = 0; tp = 0; mct = 0; ins = 0;
  endtask

  task automatic host(input int c, input int a);
    h_valid = 1; h_cmd = c[2:0]; h_arg = a[CNT_W-1:0];
  endtask

  task automatic panel(input int c, input int a);
    p_valid = 1; p_cmd = c[2:0]; p_arg = a[CNT_W-1:0];
  endtask

  task automatic bnd(input bit t, input bit m, input bit i);
    tp = t; mct = m; ins = i;
  endtask

  typedef struct {
    bit hv; bit [2:0] hc; bit pv; bit [2:0] pc; bit bd;
    bit e_hr; bit e_pr; bit e_stop; bit e_halt; bit e_busy; bit e_err;
  } vec_t;

  function automatic vec_t mk(input bit hv, input int hc, input bit pv, input int pc, input bit bd,
                              input bit hr, input bit pr, input bit st, input bit ht, input bit by, input bit er);
    vec_t v;
    v.hv = hv; v.hc = hc[2:0]; v.pv = pv; v.pc = pc[2:0]; v.bd = bd;
    v.e_hr = hr; v.e_pr = pr; v.e_stop = st; v.e_halt = ht; v.e_busy = by; v.e_err = er;
    return v;
  endfunction

  vec_t vecs[18];

  initial begin
    int c0;
    vecs[0]  = mk(1, C_RUN,  0, 0,      0, 1, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0,      0, 0,      1, 1, 1, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0,      0, 0,      1, 1, 1, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0,      0, 0,      1, 1, 1, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0,      1, C_HALT, 0, 1, 1, 0, 0, 1, 0);
    vecs[5]  = mk(0, 0,      0, 0,      0, 0, 0, 0, 0, 1, 0);
    vecs[6]  = mk(0, 0,      0, 0,      0, 0, 0, 0, 0, 1, 0);
    vecs[7]  = mk(0, 0,      0, 0,      0, 0, 0, 0, 0, 1, 0);
    vecs[8]  = mk(0, 0,      0, 0,      0, 0, 0, 0, 0, 1, 0);
    vecs[9]  = mk(0, 0,      1, C_RUN,  1, 0, 0, 1, 1, 0, 0);
    vecs[10] = mk(1, C_RSVD, 0, 0,      0, 1, 0, 1, 1, 0, 1);
    vecs[11] = mk(0, 0,      0, 0,      0, 1, 1, 1, 1, 0, 0);
    vecs[12] = mk(1, C_RUN,  0, 0,      0, 1, 0, 0, 0, 0, 0);
    vecs[13] = mk(1, C_SMCT, 0, 0,      0, 1, 0, 0, 0, 0, 1);
    vecs[14] = mk(0, 0,      0, 0,      0, 1, 1, 0, 0, 0, 0);
    vecs[15] = mk(1, C_HALT, 0, 0,      1, 1, 0, 0, 0, 1, 0);
    vecs[16] = mk(0, 0,      0, 0,      0, 0, 0, 0, 0, 1, 0);
    vecs[17] = mk(0, 0,      0, 0,      1, 0, 0, 1, 1, 0, 0);

    h_cmd = 0; p_cmd = 0; h_arg = 0; p_arg = 0;
    idle();
    rst = 1;
    @(posedge clk); @(negedge clk);
    tick();
    tick();
    rst = 0;
    chk("reset_stop", stop, 1);
    chk("reset_count", mct_count, 0);

    // directed vector table
    for (int i = 0; i < 18; i++) begin
      idle();
      h_valid = vecs[i].hv; h_cmd = vecs[i].hc;
      p_valid = vecs[i].pv; p_cmd = vecs[i].pc;
      bnd(vecs[i].bd, vecs[i].bd, 1'b0);
      tick();
      chk($sformatf("vec%0d_h_ready", i), smp_hr, vecs[i].e_hr);
      chk($sformatf("vec%0d_p_ready", i), smp_pr, vecs[i].e_pr);
      chk($sformatf("vec%0d_stop", i),    stop,   vecs[i].e_stop);
      chk($sformatf("vec%0d_halted", i),  halted, vecs[i].e_halt);
      chk($sformatf("vec%0d_busy", i),    busy,   vecs[i].e_busy);
      chk($sformatf("vec%0d_err", i),     cmd_err, vecs[i].e_err);
      if (i == 3) chk("vec_count_3", mct_count, 3);
    end
    idle();

    // STEP_TP with a coincident TPEND in the accept cycle: that pulse is ignored
    host(C_STP, 0); bnd(1, 0, 0); tick(); idle();
    chk("step_tp_running", stop, 0);
    tick(); tick();
    chk("step_tp_busy", busy, 1);
    bnd(1, 0, 0); tick(); idle();
    chk("step_tp_halted", halted, 1);
    bnd(1, 0, 0); tick(); idle();
    chk("step_tp_one_only", stop, 1);

    // STEP_INS over three MCTs
    c0 = m_cnt;
    host(C_SINS, 0); tick(); idle();
    for (int k = 1; k <= 3; k++) begin
      bnd(1, 1, k == 3); tick(); idle();
      chk($sformatf("step_ins_mct%0d", k), halted, k == 3);
      tick();
    end
    chk("step_ins_count", mct_count, (c0 + 3) % 65536);

    // BURST 4
    host(C_BURST, 4); tick(); idle();
    for (int k = 1; k <= 4; k++) begin
      bnd(1, 1, 0); tick(); idle();
      chk($sformatf("burst4_mct%0d", k), halted, k == 4);
      tick();
    end

    // BURST 0 means 2^CNT_W
    host(C_BURST, 0); tick(); idle();
    for (int k = 1; k <= 256; k++) begin
      bnd(1, 1, 0); tick(); idle();
      if (k >= 255) chk($sformatf("burst256_mct%0d", k), halted, k == 256);
    end

    // HALT mid-burst after two MCTs: halts at the third
    host(C_BURST, 10); tick(); idle();
    bnd(1, 1, 0); tick(); idle();
    bnd(1, 1, 0); tick(); idle();
    panel(C_HALT, 0); tick(); idle();
    chk("burst_halt_busy", busy, 1);
    tick(); tick();
    chk("burst_halt_wait", halted, 0);
    bnd(1, 1, 0); tick(); idle();
    chk("burst_halt_done", halted, 1);

    // simultaneous requesters: host first, panel once host drops VALID
    host(C_HALT, 0); panel(C_RUN, 0); tick();
    chk("prio_p_ready_low", smp_pr, 0);
    chk("prio_still_halted", halted, 1);
    h_valid = 0; tick(); p_valid = 0;
    chk("prio_p_ready_high", smp_pr, 1);
    chk("prio_panel_run", stop, 0);
    host(C_HALT, 0); tick(); idle();
    bnd(1, 1, 0); tick(); idle();
    chk("prio_halted_again", halted, 1);

    // reset mid-burst with a command pending during reset
    host(C_BURST, 20); tick(); idle();
    bnd(1, 1, 0); tick(); idle();
    bnd(1, 1, 0); tick(); idle();
    rst = 1; host(C_RUN, 0); tick(); rst = 0; idle();
    chk("rst_halted", halted, 1);
    chk("rst_count", mct_count, 0);
    chk("rst_busy", busy, 0);
    tick();
    chk("rst_no_pending", stop, 1);

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      if (!h_valid && $urandom_range(0, 3) == 0) host($urandom_range(0, 7), ($urandom_range(0, 39) == 0) ? 0 : $urandom_range(1, 6));
      if (!p_valid && $urandom_range(0, 3) == 0) panel($urandom_range(0, 7), $urandom_range(1, 6));
      tp  = ($urandom_range(0, 2) == 0);
      mct = tp && ($urandom_range(0, 1) == 0);
      ins = mct && ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
      rst = 0;
      if (acc_h) h_valid = 0;
      if (acc_p) p_valid = 0;
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_stop_ctrl.md
# timer_stop_ctrl

Run/halt/step controller for the AGC timer. It drives the timer's STOP input so execution freezes only on clean timing boundaries: timepulse end, memory-cycle (MCT) end or instruction end. Commands come from two requesters, the debug host and the monitor panel, each over a valid/ready handshake; fixed priority arbitrates between them. The block sits beside the timer in the top level and replaces the constant STOP register.

## Interface
- START_HALTED, 1: state after reset (1 = HALTED, 0 = RUN).
- CNT_W, 8: width of the burst-count argument.
- MCT_CNT_W, 16: width of the executed-MCT counter.

- SIM_CLK  in  1  sole clock.
- RESET  in  1  synchronous, active-high reset.
- TPEND  in  1  one-cycle pulse at the end of each timepulse.
- MCTEND  in  1  one-cycle pulse at the end of each MCT (coincides with a TPEND).
- INSTEND  in  1  one-cycle pulse at instruction end (coincides with an MCTEND).
- H_VALID, H_READY  in/out  1  host command handshake.
- H_CMD, H_ARG  in  3 / CNT_W  host command code and burst argument.
- P_VALID, P_READY  in/out  1  panel command handshake.
- P_CMD, P_ARG  in  3 / CNT_W  panel command code and burst argument.
- STOP  out  1  registered; to timer STOP.
- HALTED  out  1  registered; high in HALTED state.
- BUSY  out  1  registered; high in STOPPING, STEP_TP, STEP_MCT, STEP_INS or BURST.
- CMD_ERR  out  1  one-cycle pulse, command accepted but illegal in the current state.
- MCT_COUNT  out  MCT_CNT_W  MCTEND pulses seen while STOP=0; wraps.

## Operation
- Command codes: 0 NOP, 1 RUN, 2 HALT, 3 STEP_TP, 4 STEP_MCT, 5 STEP_INS, 6 BURST; 7 is reserved and treated as illegal.
- Accept rule: a command is accepted when VALID&&READY. The requester holds CMD and ARG stable while VALID is high.
- H_READY = accept_en.
- P_READY = accept_en && !H_VALID. Host has strict priority.
- accept_en is high in RUN, HALTED, BURST, STEP_TP, STEP_MCT and STEP_INS. It is low in STOPPING.
- States and transitions:
  - RUN:
    - HALT → STOPPING.
    - RUN and NOP: no effect.
    - Any other command → CMD_ERR.
  - STOPPING: waits for MCTEND, then → HALTED.
  - HALTED:
    - RUN → RUN.
    - STEP_TP → STEP_TP.
    - STEP_MCT → STEP_MCT.
    - STEP_INS → STEP_INS.
    - BURST → BURST with cnt = ARG, where ARG=0 means 2^CNT_W.
    - HALT and NOP: no effect.
    - Reserved code → CMD_ERR.
  - STEP_TP → HALTED on TPEND.
  - STEP_MCT → HALTED on MCTEND.
  - STEP_INS → HALTED on INSTEND.
  - BURST:
    - cnt decrements on each MCTEND.
    - The MCTEND that takes cnt from 1 to 0 → HALTED.
    - HALT → STOPPING. The burst is truncated at the next MCTEND.
  - In any step state: HALT is accepted with no effect; any other non-NOP command → CMD_ERR.
- STOP = 1 exactly in HALTED and in the reset state when START_HALTED=1.
- MCT_COUNT increments on MCTEND only when STOP=0.

## Timing
- All outputs are registered. A state change takes effect on the edge after the accept or boundary pulse.
- STOP:
  - STOP rises in the cycle after the terminating boundary pulse.
  - STOP falls in the cycle after a step, RUN or BURST command is accepted.
- Boundary pulses are ignored while HALTED.
- A boundary pulse in the same cycle as the accept of the command that leaves HALTED is ignored, because STOP was still high in that cycle.
- Accept and boundary in the same cycle in BURST or RUN: a HALT accept and an MCTEND arriving together → STOPPING. The block then waits for the next MCTEND; HALT is not back-dated.
- Simultaneous TPEND, MCTEND and INSTEND: each state uses only its own event.
- RESET mid-operation:
  - State → HALTED or RUN per START_HALTED.
  - cnt and MCT_COUNT → 0.
  - CMD_ERR → 0; BUSY → 0.
  - HALTED and STOP follow START_HALTED.
  - No pending accept survives reset.
- CMD_ERR is asserted in the cycle after the illegal accept.

## Structure
- The shared include file holds:
  - localparam command codes 0–7;
  - the state encoding (RUN, STOPPING, HALTED, STEP_TP, STEP_MCT, STEP_INS, BURST);
  - the command width, 3.
- One sub-module, timer_cmd_arb: the two-source fixed-priority arbiter. It outputs a selected cmd, arg and accept strobe.
- The FSM, burst counter and MCT counter live in timer_stop_ctrl.

## Test plan
- Reset with START_HALTED=1, then H_CMD=RUN → STOP=1 and HALTED=1 after reset; STOP=0 the cycle after accept; MCT_COUNT counts 3 after 3 MCTEND pulses.
- In RUN, P_CMD=HALT, then MCTEND 5 cycles later → BUSY=1 for those cycles; STOP=1 and HALTED=1 the cycle after MCTEND; P_READY low throughout STOPPING.
- From HALTED, STEP_TP → exactly one TPEND is consumed, then STOP=1. STEP_INS with MCTEND×3, INSTEND on the third → HALTED after the third; MCT_COUNT += 3.
- BURST ARG=4 → halts after the 4th MCTEND. BURST ARG=0 with CNT_W=8 → halts after 256. HALT issued mid-burst after 2 MCTs → halts at the 3rd.
- H_VALID and P_VALID together, both with valid commands → host accepted, P_READY=0; panel accepted the following cycle once H_VALID drops.
- STEP_MCT in RUN, or code 7 in HALTED → CMD_ERR one-cycle pulse and state unchanged. RESET asserted mid-BURST → state per START_HALTED, MCT_COUNT=0 the next cycle.
